// File: rtl/acc_icb_if.sv
// ICB command/response channel between the E203 core and the accelerator slave.
interface acc_icb_if;
   logic        icb_cmd_valid;
   logic        icb_cmd_ready;
   logic        icb_cmd_read;
   logic [31:0] icb_cmd_addr;
   logic [31:0] icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid;
   logic        icb_rsp_ready;
   logic [31:0] icb_rsp_rdata;
   logic        icb_rsp_err;

   modport master (
      output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
      output icb_rsp_ready,
      input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
   );

   modport slave (
      input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
      input  icb_rsp_ready,
      output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
   );
endinterface

// File: rtl/acc_icb_slave.sv
// ICB responder for the accelerator: CTRL/MODE registers plus a word-indexed data
// window onto the shared buffer. One transaction outstanding at a time.
module acc_icb_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
   parameter int unsigned BUF_DEPTH = 4096,
   parameter int unsigned IDX_W     = $clog2(BUF_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   acc_icb_if.slave         icb,
   output logic             buf_en,
   output logic             buf_we,
   output logic [IDX_W-1:0] buf_addr,
   output logic [31:0]      buf_wdata,
   output logic [3:0]       buf_wmask,
   input  logic [31:0]      buf_rdata,
   output logic [1:0]       mode,
   output logic             start,
   input  logic             acc_done,
   input  logic             acc_busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] RSP     = 2'd2;

   localparam logic [12:0] DEPTH_OFF = 13'(BUF_DEPTH);

   logic [1:0]  state_q, state_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  mode_q, mode_d;
   logic        start_q, start_d;
   logic        done_q, done_d;

   logic [12:0] off;
   logic [12:0] idx;
   logic        base_hit, is_ctrl, is_mode, is_data, cmd_err;
   logic        hs, data_acc;

   // Address decode of the command currently presented.
   always_comb begin
      off      = icb.icb_cmd_addr[12:0];
      idx      = off - 13'd8;
      base_hit = (icb.icb_cmd_addr[31:13] == BASE_ADDR[31:13]);
      is_ctrl  = (off == 13'd0);
      is_mode  = (off == 13'd4);
      is_data  = (off >= 13'd8);
      cmd_err  = !base_hit || (is_data && (idx >= DEPTH_OFF)) || (!is_data && !is_ctrl && !is_mode);
   end

   // Handshake only in IDLE; a reset cycle never accepts a command.
   assign icb.icb_cmd_ready = (state_q == IDLE);
   assign hs                = icb.icb_cmd_valid && icb.icb_cmd_ready && !rst;
   assign data_acc          = hs && is_data && !cmd_err;

   // Buffer strobe is driven combinationally in the handshake cycle only.
   always_comb begin
      buf_en    = data_acc;
      buf_we    = data_acc && !icb.icb_cmd_read;
      buf_addr  = data_acc ? idx[IDX_W-1:0] : '0;
      buf_wdata = (data_acc && !icb.icb_cmd_read) ?
                  {icb.icb_cmd_wdata[31:16], icb.icb_cmd_wdata[15:0]} : 32'd0;
      buf_wmask = (data_acc && !icb.icb_cmd_read) ? icb.icb_cmd_wmask : 4'd0;
   end

   // Transaction FSM, response register and register-file writes.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mode_d  = mode_q;
      start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               rdata_d = 32'd0;
               err_d   = cmd_err;
               state_d = RSP;
               if (!cmd_err) begin
                  if (icb.icb_cmd_read) begin
                     if (is_ctrl) rdata_d = {30'd0, acc_busy, done_q};
                     if (is_mode) rdata_d = {30'd0, mode_q};
                     if (is_data) state_d = RD_WAIT;
                  end else begin
                     if (is_ctrl) start_d = icb.icb_cmd_wdata[0];
                     if (is_mode && icb.icb_cmd_wmask[0]) mode_d = icb.icb_cmd_wdata[1:0];
                  end
               end
            end
         end
         RD_WAIT: begin
            rdata_d = buf_rdata;
            state_d = RSP;
         end
         RSP: begin
            if (icb.icb_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Completion flag: acc_done sets, the start pulse clears, set has priority.
   always_comb begin
      done_d = done_q;
      if (start_q) done_d = 1'b0;
      if (acc_done) done_d = 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         mode_q  <= 2'd0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   assign icb.icb_rsp_valid = (state_q == RSP);
   assign icb.icb_rsp_rdata = rdata_q;
   assign icb.icb_rsp_err   = err_q;
   assign mode              = mode_q;
   assign start             = start_q;

endmodule

// File: tb/tb_acc_icb_slave.sv
// Directed bench for acc_icb_slave with a simple synchronous buffer model.
module tb_acc_icb_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        buf_en, buf_we;
   logic [11:0] buf_addr;
   logic [31:0] buf_wdata;
   logic [3:0]  buf_wmask;
   logic [31:0] buf_rdata = 32'd0;
   logic [1:0]  mode;
   logic        start;
   logic        acc_done = 1'b0;
   logic        acc_busy = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int start_cnt = 0;
   int en_cnt = 0;

   logic        hs_en, hs_we;
   logic [11:0] hs_addr;
   logic [31:0] hs_wdata;
   logic [3:0]  hs_wmask;
   logic [31:0] mem [0:4095];

   acc_icb_if icb ();

   acc_icb_slave dut (
      .clk       (clk),
      .rst       (rst),
      .icb       (icb),
      .buf_en    (buf_en),
      .buf_we    (buf_we),
      .buf_addr  (buf_addr),
      .buf_wdata (buf_wdata),
      .buf_wmask (buf_wmask),
      .buf_rdata (buf_rdata),
      .mode      (mode),
      .start     (start),
      .acc_done  (acc_done),
      .acc_busy  (acc_busy)
   );

   always #5 clk = ~clk;

   // Buffer model: byte-masked writes, read data one cycle after the strobe.
   always @(posedge clk) begin
      if (buf_en && buf_we) begin
         for (int b = 0; b < 4; b++)
            if (buf_wmask[b]) mem[buf_addr][8*b +: 8] <= buf_wdata[8*b +: 8];
      end
      if (buf_en && !buf_we) buf_rdata <= mem[buf_addr];
   end

   always @(posedge clk) begin
      if (start) start_cnt <= start_cnt + 1;
      if (buf_en) en_cnt <= en_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete transaction with rsp_ready high; lat counts cycles from handshake to rsp_valid.
   task automatic xfer(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wm, output logic [31:0] rdata, output logic err,
                       output int lat);
      int n;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = rd;
      icb.icb_cmd_addr  = addr;
      icb.icb_cmd_wdata = wdata;
      icb.icb_cmd_wmask = wm;
      icb.icb_rsp_ready = 1'b1;
      n = 0;
      while (!icb.icb_cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", {31'd0, icb.icb_cmd_ready}, 32'd1);
      #1;
      hs_en    = buf_en;
      hs_we    = buf_we;
      hs_addr  = buf_addr;
      hs_wdata = buf_wdata;
      hs_wmask = buf_wmask;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
      lat = 1;
      while (!icb.icb_rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_wait", {31'd0, icb.icb_rsp_valid}, 32'd1);
      rdata = icb.icb_rsp_rdata;
      err   = icb.icb_rsp_err;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          en0, st0;

      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      icb.icb_cmd_valid = 1'b0;
      icb.icb_cmd_read  = 1'b0;
      icb.icb_cmd_addr  = 32'd0;
      icb.icb_cmd_wdata = 32'd0;
      icb.icb_cmd_wmask = 4'd0;
      icb.icb_rsp_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_cmd_ready", {31'd0, icb.icb_cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, icb.icb_rsp_valid}, 32'd0);
      check("rst_rsp_rdata", icb.icb_rsp_rdata, 32'd0);
      check("rst_outs", {23'd0, icb.icb_rsp_err, buf_en, buf_we, buf_wmask, mode, start}, 32'd0);
      check("rst_buf_addr_wdata", buf_wdata | {20'd0, buf_addr}, 32'd0);

      // MODE write / read
      xfer(1'b0, 32'h1004_2004, 32'h0000_0002, 4'hF, rd, er, lat);
      check("mode_wr_lat", lat, 1);
      check("mode_wr_err", {31'd0, er}, 32'd0);
      check("mode_val", {30'd0, mode}, 32'd2);
      xfer(1'b1, 32'h1004_2004, 32'd0, 4'h0, rd, er, lat);
      check("mode_rd", rd, 32'h2);
      // wmask[0] clear leaves MODE alone
      xfer(1'b0, 32'h1004_2004, 32'h0000_0001, 4'hE, rd, er, lat);
      check("mode_masked", {30'd0, mode}, 32'd2);

      // Data window write then read
      xfer(1'b0, 32'h1004_2009, 32'hBC00_3C00, 4'hF, rd, er, lat);
      check("dw_en_we", {30'd0, hs_en, hs_we}, 32'd3);
      check("dw_addr", {20'd0, hs_addr}, 32'd1);
      check("dw_wdata", hs_wdata, 32'hBC00_3C00);
      check("dw_rdata0", rd, 32'd0);
      xfer(1'b1, 32'h1004_2009, 32'd0, 4'h0, rd, er, lat);
      check("dr_en_we", {30'd0, hs_en, hs_we}, 32'd2);
      check("dr_lat", lat, 2);
      check("dr_rdata", rd, 32'hBC00_3C00);

      // Last valid index with a partial byte mask
      xfer(1'b0, 32'h1004_3007, 32'h1234_5678, 4'h3, rd, er, lat);
      check("top_idx_err", {31'd0, er}, 32'd0);
      check("top_idx_addr", {20'd0, hs_addr}, 32'd4095);
      check("top_idx_wmask", {28'd0, hs_wmask}, 32'h3);
      xfer(1'b1, 32'h1004_3007, 32'd0, 4'h0, rd, er, lat);
      check("top_idx_rd", rd, 32'h0000_5678);

      // CTRL start pulse and done_sticky
      xfer(1'b0, 32'h1004_2000, 32'd1, 4'hF, rd, er, lat);
      check("start_high", {31'd0, start}, 32'd1);
      xfer(1'b0, 32'h1004_2000, 32'd0, 4'hF, rd, er, lat);
      check("start_low", {31'd0, start}, 32'd0);
      check("start_count", start_cnt, 1);
      xfer(1'b1, 32'h1004_2000, 32'd0, 4'h0, rd, er, lat);
      check("ctrl_rd_idle", rd, 32'd0);
      @(negedge clk);
      acc_done = 1'b1;
      @(negedge clk);
      acc_done = 1'b0;
      acc_busy = 1'b1;
      xfer(1'b1, 32'h1004_2000, 32'd0, 4'h0, rd, er, lat);
      check("ctrl_rd_done", rd, 32'd3);
      xfer(1'b0, 32'h1004_2000, 32'd1, 4'hF, rd, er, lat);
      xfer(1'b1, 32'h1004_2000, 32'd0, 4'h0, rd, er, lat);
      check("ctrl_rd_cleared", rd, 32'd2);
      acc_busy = 1'b0;

      // Response stall with a second command pending
      @(negedge clk);
      en0 = en_cnt;
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = 1'b0;
      icb.icb_cmd_addr  = 32'h1004_200D;
      icb.icb_cmd_wdata = 32'hAAAA_5555;
      icb.icb_cmd_wmask = 4'hF;
      icb.icb_rsp_ready = 1'b0;
      @(negedge clk);
      icb.icb_cmd_addr  = 32'h1004_200E;
      icb.icb_cmd_wdata = 32'h1111_2222;
      for (int c = 0; c < 5; c++) begin
         check("stall_cmd_ready", {31'd0, icb.icb_cmd_ready}, 32'd0);
         check("stall_rsp", {icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata[29:0]},
               32'h8000_0000);
         if (c < 4) @(negedge clk);
      end
      check("stall_en_count", en_cnt, en0 + 1);
      icb.icb_rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("second_accept", {19'd0, buf_en, buf_we, buf_addr}, {19'd0, 2'b11, 12'd6});
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
      check("second_rsp", {31'd0, icb.icb_rsp_valid}, 32'd1);
      @(negedge clk);
      check("stall_en_total", en_cnt, en0 + 2);
      xfer(1'b1, 32'h1004_200D, 32'd0, 4'h0, rd, er, lat);
      check("stall_rd5", rd, 32'hAAAA_5555);
      xfer(1'b1, 32'h1004_200E, 32'd0, 4'h0, rd, er, lat);
      check("stall_rd6", rd, 32'h1111_2222);

      // Decode errors: no side effects
      en0 = en_cnt;
      st0 = start_cnt;
      xfer(1'b0, 32'h1004_3008, 32'h3, 4'hF, rd, er, lat);
      check("oob_wr", {er, rd[30:0]}, 32'h8000_0000);
      xfer(1'b1, 32'h1004_3008, 32'd0, 4'h0, rd, er, lat);
      check("oob_rd", {er, rd[30:0]}, 32'h8000_0000);
      check("oob_rd_lat", lat, 1);
      xfer(1'b1, 32'h1005_2000, 32'd0, 4'h0, rd, er, lat);
      check("base_rd", {er, rd[30:0]}, 32'h8000_0000);
      xfer(1'b0, 32'h1005_2000, 32'd1, 4'hF, rd, er, lat);
      check("base_wr_err", {31'd0, er}, 32'd1);
      xfer(1'b0, 32'h1005_2004, 32'd3, 4'hF, rd, er, lat);
      xfer(1'b0, 32'h1004_2005, 32'd3, 4'hF, rd, er, lat);
      check("hole_err", {31'd0, er}, 32'd1);
      @(negedge clk);
      check("err_no_en", en_cnt, en0);
      check("err_no_start", start_cnt, st0);
      check("err_mode_kept", {30'd0, mode}, 32'd2);

      // Reset while waiting on buffer read data
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = 1'b1;
      icb.icb_cmd_addr  = 32'h1004_2009;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
      check("rdwait_no_rsp", {30'd0, icb.icb_rsp_valid, icb.icb_cmd_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_rsp", {icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata[29:0]}, 32'd0);
      check("rst_mid_ready", {31'd0, icb.icb_cmd_ready}, 32'd1);
      check("rst_mid_outs", {26'd0, buf_en, buf_we, mode, start, 1'b0}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
